// File: rtl/muldiv_sequencer_if.sv
// Decode-side bundle for the multi-cycle HI/LO unit: operation launch, HI/LO moves,
// MFHI/MFLO stall request and the unit's status/results.
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [1:0]       op_i;
   logic [WIDTH-1:0] rs_i;
   logic [WIDTH-1:0] rt_i;
   logic             mthi_i;
   logic             mtlo_i;
   logic             mf_req_i;
   logic             busy_o;
   logic             done_o;
   logic             stall_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, mf_req_i,
      input  busy_o, done_o, stall_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i, mf_req_i,
      output busy_o, done_o, stall_o, hi_o, lo_o
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO: shift-add multiply and restoring
// divide at one bit per cycle on magnitudes, with sign fix-up in a final cycle.
module muldiv_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset_ni,
   muldiv_sequencer_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_quot_q, neg_quot_d;
   logic               neg_rem_q, neg_rem_d;
   logic               divzero_q, divzero_d;
   logic               done_q, done_d;

   logic               is_signed, is_div, rs_neg, rt_neg;
   logic [WIDTH-1:0]   rs_abs, rt_abs;
   logic [WIDTH:0]     mul_sum, div_shift, div_sub;
   logic               div_ge;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   assign is_signed = ~bus.op_i[0];
   assign is_div    = bus.op_i[1];
   assign rs_neg    = is_signed & bus.rs_i[WIDTH-1];
   assign rt_neg    = is_signed & bus.rt_i[WIDTH-1];
   assign rs_abs    = rs_neg ? -bus.rs_i : bus.rs_i;
   assign rt_abs    = rt_neg ? -bus.rt_i : bus.rt_i;

   // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : '0)};
   assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_ge    = (div_shift >= {1'b0, b_q});
   assign div_sub   = div_shift - {1'b0, b_q};

   assign prod_fix  = (op_q == 2'b00 && neg_quot_q) ? -acc_q : acc_q;
   assign quot_fix  = (op_q == 2'b10 && neg_quot_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   assign rem_fix   = (op_q == 2'b10 && neg_rem_q) ? -acc_q[2*WIDTH-1:WIDTH]
                                                   : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      acc_d      = acc_q;
      b_d        = b_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      cnt_d      = cnt_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      divzero_d  = divzero_q;
      done_d     = 1'b0;

      // A new start or an HI/LO move always abandons whatever is in flight, FIX included
      if (bus.start_i) begin
         op_d       = bus.op_i;
         acc_d      = {{WIDTH{1'b0}}, rs_abs};
         b_d        = rt_abs;
         neg_quot_d = rs_neg ^ rt_neg;
         neg_rem_d  = rs_neg;
         divzero_d  = is_div && (bus.rt_i == '0);
         cnt_d      = CW'(WIDTH);
         state_d    = ST_RUN;
      end else if (bus.mthi_i || bus.mtlo_i) begin
         if (bus.mthi_i) hi_d = bus.rs_i;
         if (bus.mtlo_i) lo_d = bus.rs_i;
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (op_q[1]) begin
                  acc_d = div_ge ? {div_sub[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                 : {acc_q[2*WIDTH-2:0], 1'b0};
               end else begin
                  acc_d = {mul_sum, acc_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
               if (divzero_q) begin
                  hi_d = '0;
                  lo_d = '0;
               end else if (op_q[1]) begin
                  hi_d = rem_fix;
                  lo_d = quot_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q    <= ST_IDLE;
         op_q       <= 2'b00;
         acc_q      <= '0;
         b_q        <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         cnt_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         divzero_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         acc_q      <= acc_d;
         b_q        <= b_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         cnt_q      <= cnt_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         divzero_q  <= divzero_d;
         done_q     <= done_d;
      end
   end

   assign bus.busy_o  = (state_q != ST_IDLE);
   assign bus.done_o  = done_q;
   assign bus.stall_o = bus.mf_req_i & bus.busy_o;
   assign bus.hi_o    = hi_q;
   assign bus.lo_o    = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, signed/unsigned results, divide by zero,
// stalls, aborts by start/MTHI/MTLO (including on the FIX cycle) and async reset.
module tb_muldiv_sequencer;
   logic clk = 1'b0;
   logic reset_ni = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(32)) bus ();

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset_ni (reset_ni),
      .bus      (bus.slave)
   );

   // Caller sits at a negedge; returns at the negedge right after the accepting edge (j=0)
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start_i = 1'b1; bus.op_i = op; bus.rs_i = a; bus.rt_i = b;
      @(negedge clk);
      bus.start_i = 1'b0;
   endtask

   task automatic mt_write(input logic h, input logic l, input logic [31:0] v);
      bus.mthi_i = h; bus.mtlo_i = l; bus.rs_i = v;
      @(negedge clk);
      bus.mthi_i = 1'b0; bus.mtlo_i = 1'b0;
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int done_j, output int done_cnt, output int busy_cnt,
                         output int stall_cnt);
      launch(op, a, b);
      done_j = -1; done_cnt = 0; busy_cnt = 0; stall_cnt = 0;
      for (int j = 0; j < 40; j++) begin
         if (bus.busy_o)  busy_cnt++;
         if (bus.stall_o) stall_cnt++;
         if (bus.done_o) begin
            done_cnt++;
            if (done_j < 0) done_j = j;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      bus.start_i = 0; bus.op_i = 0; bus.rs_i = 0; bus.rt_i = 0;
      bus.mthi_i = 0; bus.mtlo_i = 0; bus.mf_req_i = 1;
      reset_ni = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_o); end
      checks++; if (bus.done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_o); end
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.stall_o); end
      checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h:%h want 0:0", bus.hi_o, bus.lo_o); end
      reset_ni = 1'b1;
      bus.mf_req_i = 0;
      @(negedge clk);
      $display("reset: busy=%b done=%b hi=%h lo=%h", bus.busy_o, bus.done_o, bus.hi_o, bus.lo_o);
   endtask

   task automatic test_multu_max();
      int dj, dc, bc, sc;
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, dj, dc, bc, sc);
      $display("MULTU ffffffff*ffffffff: done_j=%0d hi=%h lo=%h", dj, bus.hi_o, bus.lo_o);
      checks++; if (dj !== 33) begin errors++; $display("FAIL multu_latency got %0d want 33", dj); end
      checks++; if (bus.hi_o !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi got %h want fffffffe", bus.hi_o); end
      checks++; if (bus.lo_o !== 32'h00000001) begin errors++; $display("FAIL multu_lo got %h want 00000001", bus.lo_o); end
   endtask

   task automatic test_mult_signed();
      int dj, dc, bc, sc;
      run_op(2'b00, 32'hFFFFFFFD, 32'd7, dj, dc, bc, sc);
      $display("MULT -3*7: done_j=%0d busy=%0d hi=%h lo=%h", dj, bc, bus.hi_o, bus.lo_o);
      checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
      checks++; if (dc !== 1) begin errors++; $display("FAIL mult_done_count got %0d want 1", dc); end
      checks++; if (bus.hi_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", bus.hi_o); end
      checks++; if (bus.lo_o !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo got %h want ffffffeb", bus.lo_o); end
   endtask

   task automatic test_divide();
      int dj, dc, bc, sc;
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, dj, dc, bc, sc);
      $display("DIV -7/2: hi=%h lo=%h", bus.hi_o, bus.lo_o);
      checks++; if (bus.lo_o !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_lo got %h want fffffffd", bus.lo_o); end
      checks++; if (bus.hi_o !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_hi got %h want ffffffff", bus.hi_o); end
      run_op(2'b10, 32'd100, 32'hFFFFFFF9, dj, dc, bc, sc);
      $display("DIV 100/-7: hi=%h lo=%h", bus.hi_o, bus.lo_o);
      checks++; if (bus.lo_o !== 32'hFFFFFFF2 || bus.hi_o !== 32'd2) begin errors++; $display("FAIL div_posneg got %h:%h want 00000002:fffffff2", bus.hi_o, bus.lo_o); end
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, dj, dc, bc, sc);
      $display("DIV min/-1: hi=%h lo=%h", bus.hi_o, bus.lo_o);
      checks++; if (bus.lo_o !== 32'h80000000 || bus.hi_o !== 32'h0) begin errors++; $display("FAIL div_overflow got %h:%h want 00000000:80000000", bus.hi_o, bus.lo_o); end
      run_op(2'b11, 32'd7, 32'd0, dj, dc, bc, sc);
      $display("DIVU 7/0: done_j=%0d hi=%h lo=%h", dj, bus.hi_o, bus.lo_o);
      checks++; if (dj !== 33) begin errors++; $display("FAIL divzero_latency got %0d want 33", dj); end
      checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin errors++; $display("FAIL divzero_hilo got %h:%h want 0:0", bus.hi_o, bus.lo_o); end
   endtask

   task automatic test_stall();
      int dj, dc, bc, sc;
      bus.mf_req_i = 1'b1;
      run_op(2'b00, 32'd5, 32'd5, dj, dc, bc, sc);
      $display("MULT 5*5 with mf_req: stall_cycles=%0d lo=%h", sc, bus.lo_o);
      checks++; if (sc !== 33) begin errors++; $display("FAIL stall_cycles got %0d want 33", sc); end
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL stall_after got %b want 0", bus.stall_o); end
      checks++; if (bus.lo_o !== 32'd25 || bus.hi_o !== 32'd0) begin errors++; $display("FAIL stall_result got %h:%h want 0:19", bus.hi_o, bus.lo_o); end
      bus.mf_req_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      int dj = -1;
      int dc = 0;
      mt_write(1'b1, 1'b0, 32'hAAAA);
      mt_write(1'b0, 1'b1, 32'h5555);
      launch(2'b11, 32'd100, 32'd7);
      for (int j = 0; j < 10; j++) begin
         if (bus.done_o) dc++;
         @(negedge clk);
      end
      launch(2'b01, 32'd3, 32'd4);
      checks++; if (bus.hi_o !== 32'hAAAA || bus.lo_o !== 32'h5555) begin errors++; $display("FAIL abort_keep got %h:%h want 0000aaaa:00005555", bus.hi_o, bus.lo_o); end
      for (int j = 0; j < 40; j++) begin
         if (bus.done_o) begin
            dc++;
            if (dj < 0) dj = j;
         end
         @(negedge clk);
      end
      $display("DIVU aborted by MULTU 3*4: done_j=%0d dones=%0d hi=%h lo=%h", dj, dc, bus.hi_o, bus.lo_o);
      checks++; if (dc !== 1) begin errors++; $display("FAIL restart_done_count got %0d want 1", dc); end
      checks++; if (dj !== 33) begin errors++; $display("FAIL restart_latency got %0d want 33", dj); end
      checks++; if (bus.lo_o !== 32'd12 || bus.hi_o !== 32'd0) begin errors++; $display("FAIL restart_result got %h:%h want 0:c", bus.hi_o, bus.lo_o); end
   endtask

   task automatic test_mt_abort();
      int dc = 0;
      mt_write(1'b0, 1'b1, 32'h5555);
      launch(2'b00, 32'd2, 32'd3);
      repeat (5) @(negedge clk);
      mt_write(1'b1, 1'b0, 32'h1234);
      $display("MTHI during MULT: busy=%b hi=%h lo=%h", bus.busy_o, bus.hi_o, bus.lo_o);
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL mthi_abort_busy got %b want 0", bus.busy_o); end
      checks++; if (bus.hi_o !== 32'h1234 || bus.lo_o !== 32'h5555) begin errors++; $display("FAIL mthi_abort_hilo got %h:%h want 00001234:00005555", bus.hi_o, bus.lo_o); end
      for (int j = 0; j < 40; j++) begin
         if (bus.done_o) dc++;
         @(negedge clk);
      end
      checks++; if (dc !== 0 || bus.hi_o !== 32'h1234) begin errors++; $display("FAIL mthi_abort_later dones=%0d hi=%h want 0 and 00001234", dc, bus.hi_o); end
   endtask

   task automatic test_fix_abort();
      int dc = 0;
      mt_write(1'b0, 1'b1, 32'h77);
      launch(2'b01, 32'd3, 32'd4);
      repeat (32) @(negedge clk);
      checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL fix_busy got %b want 1", bus.busy_o); end
      mt_write(1'b1, 1'b0, 32'h99);
      for (int j = 0; j < 40; j++) begin
         if (bus.done_o) dc++;
         @(negedge clk);
      end
      $display("MTHI on FIX cycle: dones=%0d hi=%h lo=%h", dc, bus.hi_o, bus.lo_o);
      checks++; if (dc !== 0) begin errors++; $display("FAIL fix_abort_done got %0d want 0", dc); end
      checks++; if (bus.hi_o !== 32'h99 || bus.lo_o !== 32'h77) begin errors++; $display("FAIL fix_abort_hilo got %h:%h want 00000099:00000077", bus.hi_o, bus.lo_o); end
   endtask

   task automatic test_mt_idle();
      mt_write(1'b1, 1'b1, 32'hCAFE);
      $display("MTHI+MTLO idle: hi=%h lo=%h", bus.hi_o, bus.lo_o);
      checks++; if (bus.hi_o !== 32'hCAFE || bus.lo_o !== 32'hCAFE) begin errors++; $display("FAIL mt_both got %h:%h want 0000cafe:0000cafe", bus.hi_o, bus.lo_o); end
   endtask

   task automatic test_start_beats_mt();
      bus.mthi_i = 1'b1;
      launch(2'b01, 32'd2, 32'd3);
      bus.mthi_i = 1'b0;
      checks++; if (bus.hi_o !== 32'hCAFE || bus.busy_o !== 1'b1) begin errors++; $display("FAIL start_over_mt got hi=%h busy=%b want 0000cafe 1", bus.hi_o, bus.busy_o); end
      repeat (40) @(negedge clk);
      $display("MULTU 2*3 with MTHI: hi=%h lo=%h", bus.hi_o, bus.lo_o);
      checks++; if (bus.hi_o !== 32'd0 || bus.lo_o !== 32'd6) begin errors++; $display("FAIL start_over_mt_result got %h:%h want 0:6", bus.hi_o, bus.lo_o); end
   endtask

   task automatic test_reset_mid();
      int dc = 0;
      launch(2'b10, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      #2 reset_ni = 1'b0;
      #1;
      $display("reset mid-DIV: busy=%b hi=%h lo=%h", bus.busy_o, bus.hi_o, bus.lo_o);
      checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.busy_o); end
      checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin errors++; $display("FAIL midreset_hilo got %h:%h want 0:0", bus.hi_o, bus.lo_o); end
      @(negedge clk);
      reset_ni = 1'b1;
      for (int j = 0; j < 40; j++) begin
         if (bus.done_o || bus.busy_o) dc++;
         @(negedge clk);
      end
      checks++; if (dc !== 0) begin errors++; $display("FAIL midreset_activity got %0d want 0", dc); end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_mult_signed();
      test_divide();
      test_stall();
      test_back_to_back();
      test_mt_abort();
      test_fix_abort();
      test_mt_idle();
      test_start_beats_mt();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
